vector_memory_responder: RTL and testbench

VECTOR_MEMORY_RESPONDER -- requirements
Module: vector_memory_responder

---
 rtl/vector_memory_responder.sv | 126 ++++++++++++
 tb/tb_vector_memory_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_memory_responder.sv
// 256-bit word memory with a byte-enabled processor port, a low-priority debug port,
// access counters and a sticky out-of-range flag. Optional macro: VMEM_WRITE_FWD_EN.
`timescale 1ns / 1ps

module vector_memory_responder #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rden,
  input  logic             wren,
  input  logic [13:0]      ip_address,
  input  logic [31:0]      byteena,
  input  logic [255:0]     writeData,
  output logic [255:0]     readData,
  input  logic             dbg_valid,
  input  logic             dbg_we,
  input  logic [13:0]      dbg_addr,
  input  logic [255:0]     dbg_wdata,
  output logic             dbg_ready,
  output logic             dbg_rvalid,
  output logic [255:0]     dbg_rdata,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  output logic             addr_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [255:0] mem [DEPTH];

  logic             proc_in_range;
  logic             dbg_in_range;
  logic             dbg_accept;
  logic [AW-1:0]    proc_idx;
  logic [AW-1:0]    dbg_idx;
  logic [255:0]     proc_old;
  logic [255:0]     proc_merged;
  logic [255:0]     proc_rd_word;

  logic [255:0]     rdata_q;
  logic [255:0]     drdata_q;
  logic             rvalid_q;
  logic [CNT_W-1:0] rd_cnt_q;
  logic [CNT_W-1:0] wr_cnt_q;
  logic             err_q;

  assign proc_in_range = {18'd0, ip_address} < DEPTH;
  assign dbg_in_range  = {18'd0, dbg_addr} < DEPTH;
  assign proc_idx      = ip_address[AW-1:0];
  assign dbg_idx       = dbg_addr[AW-1:0];

  // Processor traffic always wins; debug only proceeds in fully idle cycles.
  assign dbg_accept = dbg_valid & ~rden & ~wren & ~reset;

  assign proc_old = mem[proc_idx];

  always_comb begin
    proc_merged = proc_old;
    for (int i = 0; i < 32; i++) begin
      if (byteena[i]) begin
        proc_merged[8*i +: 8] = writeData[8*i +: 8];
      end
    end
  end

`ifdef VMEM_WRITE_FWD_EN
  assign proc_rd_word = wren ? proc_merged : proc_old;
`else
  assign proc_rd_word = proc_old;
`endif

  // Memory is never cleared so its contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wren && proc_in_range) begin
        for (int i = 0; i < 32; i++) begin
          if (byteena[i]) begin
            mem[proc_idx][8*i +: 8] <= writeData[8*i +: 8];
          end
        end
      end
      if (dbg_accept && dbg_we && dbg_in_range) begin
        mem[dbg_idx] <= dbg_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q  <= '0;
      drdata_q <= '0;
      rvalid_q <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (rden) begin
        rdata_q  <= proc_in_range ? proc_rd_word : '0;
        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end
      if (wren) begin
        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      end
      rvalid_q <= dbg_accept & ~dbg_we;
      if (dbg_accept && !dbg_we) begin
        drdata_q <= dbg_in_range ? mem[dbg_idx] : '0;
      end
      if (((rden || wren) && !proc_in_range) || (dbg_accept && !dbg_in_range)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Outputs read as their reset values for the whole time reset is high, which also
  // suppresses a debug return whose acceptance immediately preceded reset.
  assign dbg_ready  = dbg_accept;
  assign readData   = reset ? '0 : rdata_q;
  assign dbg_rdata  = reset ? '0 : drdata_q;
  assign dbg_rvalid = rvalid_q & ~reset;
  assign rd_count   = reset ? '0 : rd_cnt_q;
  assign wr_count   = reset ? '0 : wr_cnt_q;
  assign addr_err   = err_q & ~reset;

endmodule

// File: tb/tb_vector_memory_responder.sv
// Bench for vector_memory_responder: directed table, corner sequences, then random
// traffic against a word-array reference model (DEPTH=16, CNT_W=4).
`timescale 1ns / 1ps

module tb_vector_memory_responder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 4;
`ifdef VMEM_WRITE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             rden = 1'b0;
  logic             wren = 1'b0;
  logic [13:0]      ip_address = '0;
  logic [31:0]      byteena = '0;
  logic [255:0]     writeData = '0;
  logic [255:0]     readData;
  logic             dbg_valid = 1'b0;
  logic             dbg_we = 1'b0;
  logic [13:0]      dbg_addr = '0;
  logic [255:0]     dbg_wdata = '0;
  logic             dbg_ready;
  logic             dbg_rvalid;
  logic [255:0]     dbg_rdata;
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] wr_count;
  logic             addr_err;

  vector_memory_responder #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rden      (rden),
    .wren      (wren),
    .ip_address(ip_address),
    .byteena   (byteena),
    .writeData (writeData),
    .readData  (readData),
    .dbg_valid (dbg_valid),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ready (dbg_ready),
    .dbg_rvalid(dbg_rvalid),
    .dbg_rdata (dbg_rdata),
    .rd_count  (rd_count),
    .wr_count  (wr_count),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [255:0]     m_mem [DEPTH];
  logic [255:0]     m_rd;
  logic [255:0]     m_drd;
  logic             m_rvalid;
  logic             m_err;
  logic [CNT_W-1:0] m_rc;
  logic [CNT_W-1:0] m_wc;

  typedef struct {
    logic         r;
    logic         w;
    logic [13:0]  a;
    logic [31:0]  be;
    logic [255:0] wd;
    logic [255:0] exp_rd;
    logic         exp_err;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] merge(input logic [255:0] old, input logic [31:0] be,
                                         input logic [255:0] wd);
    logic [255:0] res;
    res = old;
    for (int i = 0; i < 32; i++) if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
    return res;
  endfunction

  task automatic model_reset();
    m_rd = '0;
    m_drd = '0;
    m_rvalid = 1'b0;
    m_err = 1'b0;
    m_rc = '0;
    m_wc = '0;
  endtask

  task automatic check_outputs();
    chk("readData", readData, m_rd);
    chk("dbg_rvalid", dbg_rvalid, m_rvalid);
    chk("dbg_rdata", dbg_rdata, m_drd);
    chk("rd_count", rd_count, m_rc);
    chk("wr_count", wr_count, m_wc);
    chk("addr_err", addr_err, m_err);
  endtask

  task automatic idle_inputs();
    rden = 1'b0;
    wren = 1'b0;
    dbg_valid = 1'b0;
    dbg_we = 1'b0;
  endtask

  task automatic step(input logic r, input logic w, input logic [13:0] a, input logic [31:0] be,
                      input logic [255:0] wd, input logic dv, input logic dwe,
                      input logic [13:0] da, input logic [255:0] dwd);
    logic exp_ready;
    rden = r; wren = w; ip_address = a; byteena = be; writeData = wd;
    dbg_valid = dv; dbg_we = dwe; dbg_addr = da; dbg_wdata = dwd;
    #1;
    exp_ready = dv & ~r & ~w;
    chk("dbg_ready", dbg_ready, exp_ready);
    m_rvalid = 1'b0;
    if (r) begin
      if (a < DEPTH) m_rd = (FWD && w) ? merge(m_mem[a[3:0]], be, wd) : m_mem[a[3:0]];
      else m_rd = '0;
      m_rc = m_rc + 1'b1;
    end
    if (w) begin
      if (a < DEPTH) m_mem[a[3:0]] = merge(m_mem[a[3:0]], be, wd);
      m_wc = m_wc + 1'b1;
    end
    if ((r || w) && a >= DEPTH) m_err = 1'b1;
    if (exp_ready) begin
      if (da >= DEPTH) m_err = 1'b1;
      if (dwe) begin
        if (da < DEPTH) m_mem[da[3:0]] = dwd;
      end else begin
        m_drd = (da < DEPTH) ? m_mem[da[3:0]] : '0;
        m_rvalid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic proc(input logic r, input logic w, input logic [13:0] a,
                      input logic [31:0] be, input logic [255:0] wd);
    step(r, w, a, be, wd, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_readData", readData, '0);
    chk("rst_dbg_rdata", dbg_rdata, '0);
    chk("rst_dbg_rvalid", dbg_rvalid, 1'b0);
    chk("rst_dbg_ready", dbg_ready, 1'b0);
    chk("rst_rd_count", rd_count, '0);
    chk("rst_wr_count", wr_count, '0);
    chk("rst_addr_err", addr_err, 1'b0);
    reset = 1'b0;
    idle_inputs();
    model_reset();
  endtask

  initial begin
    logic [255:0] a5, w33, w11, lo22;
    a5   = {32{8'hA5}};
    w33  = {32{8'h33}};
    w11  = {32{8'h11}};
    lo22 = {{31{8'h11}}, 8'h22};
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    model_reset();

    tbl[0]  = '{1'b0, 1'b1, 14'd5,  32'hFFFF_FFFF, a5,          '0,   1'b0};
    tbl[1]  = '{1'b1, 1'b0, 14'd5,  32'h0,         '0,          a5,   1'b0};
    tbl[2]  = '{1'b0, 1'b1, 14'd7,  32'hFFFF_FFFF, '0,          a5,   1'b0};
    tbl[3]  = '{1'b0, 1'b1, 14'd7,  32'h0000_000F, {32{8'hFF}}, a5,   1'b0};
    tbl[4]  = '{1'b1, 1'b0, 14'd7,  32'h0,         '0,
                {224'd0, 32'hFFFF_FFFF}, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 14'd9,  32'hFFFF_FFFF, w11, {224'd0, 32'hFFFF_FFFF}, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 14'd9,  32'h0000_0001, {32{8'h22}}, FWD ? lo22 : w11, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 14'd9,  32'h0,         '0,          lo22, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 14'd4,  32'hFFFF_FFFF, w33,         lo22, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 14'd20, 32'hFFFF_FFFF, {32{8'hFF}}, lo22, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 14'd20, 32'h0,         '0,          '0,   1'b1};
    tbl[11] = '{1'b1, 1'b0, 14'd4,  32'h0,         '0,          w33,  1'b1};
    tbl[12] = '{1'b1, 1'b0, 14'd5,  32'h0,         '0,          a5,   1'b1};

    do_reset();

    for (int i = 0; i < 13; i++) begin
      proc(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].be, tbl[i].wd);
      chk($sformatf("tbl%0d_readData", i), readData, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_addr_err", i), addr_err, tbl[i].exp_err);
      if (i == 1) begin
        chk("first_wr_count", wr_count, 4'd1);
        chk("first_rd_count", rd_count, 4'd1);
      end
    end

    // Writes during reset are ignored; contents survive; first cycle after reset serviced.
    reset = 1'b1;
    wren = 1'b1; ip_address = 14'd5; byteena = 32'hFFFF_FFFF; writeData = '0;
    dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 14'd4; dbg_wdata = '0;
    do_reset();
    proc(1'b1, 1'b0, 14'd5, '0, '0);
    chk("preserved_word5", readData, a5);
    chk("err_cleared", addr_err, 1'b0);
    proc(1'b1, 1'b0, 14'd4, '0, '0);
    chk("preserved_word4", readData, w33);

    // Debug write, then a debug read starved by three processor reads.
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 14'd3, {8{32'hDEAD_BEEF}});
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 14'd5, '0, '0, 1'b1, 1'b0, 14'd3, '0);
      chk("starved_no_rvalid", dbg_rvalid, 1'b0);
    end
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 14'd3, '0);
    chk("dbg_rvalid_pulse", dbg_rvalid, 1'b1);
    chk("dbg_rdata_word3", dbg_rdata, {8{32'hDEAD_BEEF}});
    chk("readData_untouched", readData, a5);
    proc(1'b0, 1'b0, '0, '0, '0);
    chk("dbg_rvalid_single", dbg_rvalid, 1'b0);
    chk("dbg_rdata_held", dbg_rdata, {8{32'hDEAD_BEEF}});

    // Debug read accepted just before reset must not return.
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 14'd3, '0);
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("no_rvalid_into_reset", dbg_rvalid, 1'b0);
    do_reset();

    // Counter wrap with CNT_W=4.
    for (int i = 0; i < 15; i++) proc(1'b1, 1'b0, 14'd5, '0, '0);
    chk("rd_count_15", rd_count, 4'd15);
    proc(1'b1, 1'b0, 14'd5, '0, '0);
    chk("rd_count_wrap", rd_count, 4'd0);

    // Random traffic: initialise every word, then mixed requests.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      proc(1'b0, 1'b1, 14'(i), 32'hFFFF_FFFF,
           {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    end
    for (int n = 0; n < 400; n++) begin
      logic [255:0] rw, rdw;
      rw  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rdw = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           14'($urandom_range(0, 17)), $urandom, rw,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           14'($urandom_range(0, 16)), rdw);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
